// File: rtl/norm2_job_ctrl_if.sv
// Host-side bundle for norm2_job_ctrl: sample stream in, kernel array/control port, result stream out.
interface norm2_job_ctrl_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 27
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 in_last;

    logic                 k_control_arr;
    logic                 k_wen;
    logic [AW-1:0]        k_addr;
    logic [DW-1:0]        k_wdata;
    logic [AW-1:0]        k_init_i;
    logic [63:0]          k_init_acc;
    logic                 k_r_enable;
    logic                 k_w_enable;
    logic signed [63:0]   k_result;

    logic                 res_valid;
    logic                 res_ready;
    logic signed [63:0]   res_data;
    logic [31:0]          res_cycles;
    logic [AW:0]          res_words;
    logic                 res_error;

    // Controller side.
    modport slave (
        input  in_valid, in_data, in_last, k_w_enable, k_result, res_ready,
        output in_ready, k_control_arr, k_wen, k_addr, k_wdata, k_init_i, k_init_acc,
               k_r_enable, res_valid, res_data, res_cycles, res_words, res_error
    );

    // Host stream logic plus kernel side.
    modport master (
        output in_valid, in_data, in_last, k_w_enable, k_result, res_ready,
        input  in_ready, k_control_arr, k_wen, k_addr, k_wdata, k_init_i, k_init_acc,
               k_r_enable, res_valid, res_data, res_cycles, res_words, res_error
    );
endinterface

// File: rtl/norm2_job_ctrl.sv
// Job sequencer for the norm2 kernel: loads and zero-fills the array, starts the kernel,
// times the run and returns the sum-of-squares result with word count and timeout flag.
module norm2_job_ctrl #(
    parameter int unsigned LEN     = 1000,
    parameter int unsigned AW      = 10,
    parameter int unsigned DW      = 27,
    parameter int unsigned TIMEOUT = 100000
) (
    input logic             clk,
    input logic             rst,
    norm2_job_ctrl_if.slave bus
);
    localparam int unsigned CW = 32;
    localparam int unsigned RW = 64;
    localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL_WORDS = (AW+1)'(LEN);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_FILL,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            ctl_q, ctl_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            ren_q, ren_d;
    logic            res_valid_q, res_valid_d;
    logic [RW-1:0]   res_data_q, res_data_d;
    logic [CW-1:0]   res_cycles_q, res_cycles_d;
    logic [AW:0]     res_words_q, res_words_d;
    logic            res_error_q, res_error_d;
    logic            accept_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            ctl_q        <= 1'b1;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ren_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_cycles_q <= '0;
            res_words_q  <= '0;
            res_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            ctl_q        <= ctl_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ren_q        <= ren_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_cycles_q <= res_cycles_d;
            res_words_q  <= res_words_d;
            res_error_q  <= res_error_d;
        end
    end

    // Kernel-facing outputs are decided here and appear one cycle later, so the last array
    // write lands in the START cycle and the start pulse in the first RUN cycle.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        wen_d        = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ren_d        = 1'b0;
        res_data_d   = res_data_q;
        res_cycles_d = res_cycles_q;
        res_words_d  = res_words_q;
        res_error_d  = res_error_q;
        accept_c     = bus.in_valid & in_ready_q;

        unique case (state_q)
            ST_LOAD: begin
                if (accept_c) begin
                    wen_d   = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = bus.in_data;
                    ptr_d   = ptr_q + AW'(1);
                    if (ptr_q == LAST_ADDR) begin
                        state_d     = ST_START;
                        res_words_d = FULL_WORDS;
                    end else if (bus.in_last) begin
                        state_d     = ST_FILL;
                        res_words_d = {1'b0, ptr_q} + (AW+1)'(1);
                    end
                end
            end
            ST_FILL: begin
                wen_d   = 1'b1;
                addr_d  = ptr_q;
                wdata_d = '0;
                ptr_d   = ptr_q + AW'(1);
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                ren_d   = 1'b1;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
                if (bus.k_w_enable) begin
                    res_data_d   = bus.k_result;
                    res_cycles_d = cnt_q;
                    res_error_d  = 1'b0;
                    state_d      = ST_DONE;
                end else if (cnt_q >= TO_LAST) begin
                    res_data_d   = '0;
                    res_cycles_d = cnt_q;
                    res_error_d  = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    ptr_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        in_ready_d  = (state_d == ST_LOAD);
        ctl_d       = (state_d == ST_LOAD) || (state_d == ST_FILL) || (state_d == ST_START);
        res_valid_d = (state_d == ST_DONE);
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.k_control_arr = ctl_q;
    assign bus.k_wen         = wen_q;
    assign bus.k_addr        = addr_q;
    assign bus.k_wdata       = wdata_q;
    assign bus.k_init_i      = '0;
    assign bus.k_init_acc    = '0;
    assign bus.k_r_enable    = ren_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_data      = res_data_q;
    assign bus.res_cycles    = res_cycles_q;
    assign bus.res_words     = res_words_q;
    assign bus.res_error     = res_error_q;
endmodule

// File: doc/norm2_job_ctrl.md
Name: norm2_job_ctrl

Overview:
Host-side sequencer for the norm2 kernel (sum of squares over an on-chip array of signed samples).
- Accepts a sample stream over valid/ready and writes it into the kernel array through the kernel's external array-control port, zero-filling unused words.
- Pulses the kernel start, waits for its done strobe, then returns the 64-bit result plus a cycle count over a valid/ready result port.
- Sits between the host stream logic and the kernel `main`; owns every kernel control signal.

Parameters:
- LEN, 1000: array depth, i.e. words per job.
- AW, 10: kernel array address width; requires 2^AW >= LEN.
- DW, 27: sample width, signed.
- TIMEOUT, 100000: maximum number of RUN cycles before the job is aborted.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid & in_ready.
- in_data  in  DW  signed sample.
- in_last  in  1  marks the final sample of a job when the job is shorter than LEN.
- k_control_arr  out  1  1 = controller owns the kernel array port.
- k_wen  out  1  kernel array write enable.
- k_addr  out  AW  kernel array address.
- k_wdata  out  DW  kernel array write data.
- k_init_i  out  AW  kernel loop-index init; constant 0.
- k_init_acc  out  64  kernel accumulator init; constant 0.
- k_r_enable  out  1  kernel start pulse.
- k_w_enable  in  1  kernel done strobe.
- k_result  in  64  kernel result, signed; valid while k_w_enable = 1.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid & res_ready.
- res_data  out  64  latched kernel result.
- res_cycles  out  32  cycles from k_r_enable until k_w_enable; saturates at all-ones.
- res_words  out  AW+1  real (non-fill) samples in this job, range 1..LEN.
- res_error  out  1  1 = job aborted on timeout; res_data = 0.

Behaviour:
- Reset values: state = LOAD, ptr = 0, in_ready = 1 (from the first post-reset cycle), k_control_arr = 1, k_wen = 0, k_addr = 0, k_wdata = 0, k_r_enable = 0, res_valid = 0, res_data = 0, res_cycles = 0, res_words = 0, res_error = 0.
- Reset mid-operation (any state): same reset values apply. An in-flight kernel run is abandoned. A later k_w_enable is ignored unless state = RUN.
- All kernel-facing outputs are registered. A write accepted or generated at edge t is driven during cycle t+1, and the kernel commits it at edge t+2.
- k_control_arr = 1 in every cycle where k_wen = 1. It is 0 from the k_r_enable cycle through RUN and DONE.
- LOAD state:
  - in_ready = 1.
  - On a handshake, drive k_wen = 1, k_addr = ptr, k_wdata = in_data, then ptr++.
  - If ptr == LEN-1, go to START. In this case in_last is don't-care.
  - Else if in_last = 1, go to FILL and latch res_words = ptr+1.
  - in_valid gaps leave ptr unchanged and drive k_wen = 0.
- FILL state:
  - in_ready = 0.
  - Each cycle write 0 to address ptr and increment ptr. After the write to address LEN-1, go to START.
  - Zero words do not change the sum of squares.
- START state: one cycle. in_ready = 0, k_wen = 0, k_r_enable = 1, cycle counter cleared. Go to RUN. k_r_enable is exactly one cycle wide and never asserted outside START.
- RUN state:
  - The counter increments every cycle, saturating.
  - On k_w_enable: latch k_result into res_data, latch the counter into res_cycles, set res_error = 0, go to DONE.
  - If the counter reaches TIMEOUT first: set res_data = 0, res_error = 1, go to DONE. A late k_w_enable after the timeout is ignored.
- DONE state:
  - res_valid = 1. res_data, res_cycles, res_words and res_error are stable until the handshake. in_ready = 0.
  - On res_ready: res_valid = 0 next cycle, ptr = 0, go to LOAD, k_control_arr = 1.
  - A new sample can be accepted in the cycle after the result handshake.
- A full-length job (no in_last) sets res_words = LEN.
- k_init_i and k_init_acc are tied to 0 at all times.

Test Plan:
- Full job: LEN = 1000 random samples in [-2^26, 2^26-1], no gaps, res_ready = 1 -> res_data equals the golden 64-bit sum of squares; res_words = 1000; res_error = 0; exactly one k_r_enable pulse; k_addr covers 0..999 in order.
- Short job: samples 3, -4, 5 with in_last on the third -> addresses 3..999 written with 0; res_data = 50; res_words = 3.
- Stream gaps and backpressure: in_valid toggled randomly, res_ready held 0 for 20 cycles -> result unchanged; res_valid held; in_ready = 0 until the handshake; the next job starts the cycle after it.
- Timeout: kernel model that never asserts k_w_enable, TIMEOUT = 50 -> res_valid 50 cycles after START with res_error = 1 and res_data = 0. A k_w_enable injected later is ignored.
- Reset mid-RUN and mid-LOAD: rst pulsed for one cycle -> all outputs at reset values next cycle. A following 2-sample job (7, 1, in_last) gives res_data = 50.
- Single-sample boundary: one sample -32 with in_last -> 999 fill writes; res_data = 1024; res_words = 1.
